// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge
//   Memory-side stage of the data cache. It turns the cache's single-word
//   strobe/ready request port into single-beat AXI4 read and write transactions.
//   Only one transaction is in flight at a time. It also keeps saturating counts
//   of completed reads and writes.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_addr/req_wdata/req_strobe    cache request: address, write data, valid
//   req_wen/req_size/req_rw          byte enables, size (0=B,1=H,2=W), 0=read 1=write
//   req_rdata/req_ready              read data and one-cycle completion pulse
//   ar*/r*                           AXI read address and read data channels
//   aw*/w*/b*                        AXI write address, write data and response channels
//   rd_cnt/wr_cnt                    completed read/write transactions (saturating)
//
// AXI len=0, burst=INCR and id=0 are tied off by the instantiating level, and
// RRESP/BRESP are not used here, so those signals are not ports of this block.
module dcache_axi_bridge #(
    parameter int A_WIDTH   = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [A_WIDTH-1:0]   req_addr,
    input  logic [31:0]          req_wdata,
    input  logic                 req_strobe,
    input  logic [3:0]           req_wen,
    input  logic [1:0]           req_size,
    input  logic                 req_rw,
    output logic [31:0]          req_rdata,
    output logic                 req_ready,
    output logic [A_WIDTH-1:0]   araddr,
    output logic [2:0]           arsize,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [31:0]          rdata,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [A_WIDTH-1:0]   awaddr,
    output logic [2:0]           awsize,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic                 bvalid,
    output logic                 bready,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    output logic [CNT_WIDTH-1:0] wr_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AWW,
        B,
        RESP,
        HOLD
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t next_state;

    // A channel counts as finished once its valid has already dropped, or when
    // its handshake happens this cycle; this lets AW and W complete in either
    // order or together.
    logic aw_done;
    logic w_done;

    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid  || wready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. HOLD exists so that a strobe the cache has not yet
    // lowered after req_ready is not taken as a second request.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req_strobe) begin
                    next_state = req_rw ? AWW : AR;
                end
            end
            AR: begin
                if (arready) begin
                    next_state = R;
                end
            end
            R: begin
                if (rvalid) begin
                    next_state = RESP;
                end
            end
            AWW: begin
                if (aw_done && w_done) begin
                    next_state = B;
                end
            end
            B: begin
                if (bvalid) begin
                    next_state = RESP;
                end
            end
            RESP: next_state = HOLD;
            HOLD: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered AXI and cache-side outputs. Address/data fields are loaded
    // only when a request is accepted, so they stay stable while valid is high.
    // The counters step on entry to RESP so they line up with req_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_rdata <= '0;
            req_ready <= 1'b0;
            araddr    <= '0;
            arsize    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            awsize    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            req_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_strobe) begin
                        if (req_rw) begin
                            awaddr  <= req_addr;
                            awsize  <= {1'b0, req_size};
                            wdata   <= req_wdata;
                            wstrb   <= req_wen;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            araddr  <= req_addr;
                            arsize  <= {1'b0, req_size};
                            arvalid <= 1'b1;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        req_rdata <= rdata;
                        req_ready <= 1'b1;
                        if (rd_cnt != '1) begin
                            rd_cnt <= rd_cnt + CNT_ONE;
                        end
                    end
                end
                AWW: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        req_rdata <= '0;
                        req_ready <= 1'b1;
                        if (wr_cnt != '1) begin
                            wr_cnt <= wr_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
